// File: rtl/hilo_md_if.sv
// hilo_md_if: execute-stage request/response bundle for the HI/LO mul/div unit.
// master = pipeline side, slave = hilo_md.
interface hilo_md_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  stall_req, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output stall_req, done, hi, lo
  );
endinterface

// File: rtl/hilo_md.sv
// hilo_md: MIPS HI/LO registers with iterative MULT/MULTU and restoring DIV/DIVU.
// Optional HILO_DIV_EARLY_EN retires divides with |b| > |a| at the accept edge.
module hilo_md #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_ITERS  = 32
) (
  input  logic     clk,
  input  logic     reset,
  hilo_md_if.slave bus
);
  localparam int CW = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt;
  logic [31:0]   mul_a, mul_b;
  logic          mul_sgn;
  logic [31:0]   quo, rem, dvs;
  logic          q_neg, r_neg;
  logic [31:0]   hi_q, lo_q;

  logic          ld_mul, ld_div;
  logic          wr_hi, wr_lo;
  logic [31:0]   hi_d, lo_d;
  logic          stall, done_o;

  logic is_mul, is_div, is_mthi, is_mtlo;
  logic sgn_op;

  assign is_mul  = (bus.op == 3'd0) || (bus.op == 3'd1);
  assign is_div  = (bus.op == 3'd2) || (bus.op == 3'd3);
  assign is_mthi = (bus.op == 3'd4);
  assign is_mtlo = (bus.op == 3'd5);
  // MULT and DIV are the even opcodes
  assign sgn_op  = ~bus.op[0];

  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;

  assign a_neg = sgn_op & bus.src_a[31];
  assign b_neg = sgn_op & bus.src_b[31];
  assign abs_a = a_neg ? 32'd0 - bus.src_a : bus.src_a;
  assign abs_b = b_neg ? 32'd0 - bus.src_b : bus.src_b;

  logic early;
`ifdef HILO_DIV_EARLY_EN
  assign early = (abs_b != 32'd0) && (abs_b > abs_a);
`else
  assign early = 1'b0;
`endif

  logic [63:0] ext_a, ext_b, prod;

  assign ext_a = {{32{mul_sgn & mul_a[31]}}, mul_a};
  assign ext_b = {{32{mul_sgn & mul_b[31]}}, mul_b};
  // low 64 bits of the product are the same for both signednesses
  assign prod  = ext_a * ext_b;

  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] rem_st, quo_st;
  logic [31:0] quo_fix, rem_fix;

  assign rem_sh  = {rem, quo[31]};
  assign take    = rem_sh >= {1'b0, dvs};
  assign rem_st  = take ? rem_sh[31:0] - dvs : rem_sh[31:0];
  assign quo_st  = {quo[30:0], take};
  assign quo_fix = q_neg ? 32'd0 - quo_st : quo_st;
  assign rem_fix = r_neg ? 32'd0 - rem_st : rem_st;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done_o  = 1'b0;
    ld_mul  = 1'b0;
    ld_div  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          unique case (1'b1)
            is_mul: begin
              stall   = 1'b1;
              ld_mul  = 1'b1;
              state_d = MUL;
            end
            is_div: begin
              stall = 1'b1;
              if (early) begin
                wr_hi   = 1'b1;
                wr_lo   = 1'b1;
                hi_d    = bus.src_a;
                lo_d    = 32'd0;
                state_d = DONE;
              end else begin
                ld_div  = 1'b1;
                state_d = DIV;
              end
            end
            is_mthi: begin
              wr_hi = 1'b1;
              hi_d  = bus.src_a;
            end
            is_mtlo: begin
              wr_lo = 1'b1;
              lo_d  = bus.src_a;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          wr_hi   = 1'b1;
          wr_lo   = 1'b1;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = DONE;
        end
      end
      DIV: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          wr_hi   = 1'b1;
          wr_lo   = 1'b1;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (ld_mul) begin
        mul_a   <= bus.src_a;
        mul_b   <= bus.src_b;
        mul_sgn <= sgn_op;
        cnt     <= CW'(MUL_CYCLES - 1);
      end else if (ld_div) begin
        quo   <= abs_a;
        dvs   <= abs_b;
        rem   <= '0;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        cnt   <= CW'(DIV_ITERS - 1);
      end else if ((state_q == MUL || state_q == DIV) && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state_q == DIV) begin
        quo <= quo_st;
        rem <= rem_st;
      end
      if (wr_hi) hi_q <= hi_d;
      if (wr_lo) lo_q <= lo_d;
    end
  end

  assign bus.stall_req = stall;
  assign bus.done      = done_o;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: doc/hilo_md.md
Name: hilo_md

Overview:
- Multiply/divide unit holding the architectural HI/LO registers for the MIPS core.
- Sits in the execute stage, directly upstream of the exception-commit stage.
- Its hi/lo outputs are the source of the commit stage's HI/LO read data (MFHI/MFLO).
- Its flush input is driven by the commit stage's exception-taken signal.
- Executes MULT/MULTU with an iterative multiplier and DIV/DIVU with a radix-2 restoring divider; MTHI/MTLO are single-cycle writes.
- Stalls the pipeline while busy.

Parameters:
- MUL_CYCLES, 3: cycles spent in MUL state (1..8); result written on the last of them.
- DIV_ITERS, 32: restoring-divider iterations; fixed at 32 for 32-bit operands; counter width derived from it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  instruction in execute stage targets this unit; held stable by upstream until done or flush.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved (no-op).
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception committed; abandon in-flight op, suppress writes this cycle.
- stall_req  out  1  hold execute stage and all younger stages.
- done  out  1  one-cycle pulse: mul/div result written, instruction may advance.
- hi  out  32  architectural HI (registered).
- lo  out  32  architectural LO (registered).

Behaviour:
- Reset (async, any state): state=IDLE, hi=lo=0, counter=0, done=0, stall_req=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_valid & op∈{MULT,MULTU} & !flush: latch operands and signedness; cnt=MUL_CYCLES-1; -> MUL.
  - op_valid & op∈{DIV,DIVU} & !flush: latch absolute values plus quotient/remainder signs; cnt=31; -> DIV.
  - op_valid & op∈{MTHI,MTLO} & !flush: write hi/lo at this edge; stay IDLE; no stall, no done.
- MUL: cnt decrements each cycle. At cnt==0, write {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU) at the edge; -> DONE.
- DIV: one restoring step per cycle. At the edge leaving the final iteration (cnt==0):
  - Apply sign fixups: quotient negated if sign(a)^sign(b) (DIV only); remainder takes sign of a.
  - Write lo=quotient, hi=remainder; -> DONE.
- DONE: done=1 for exactly this cycle, stall_req=0, op_valid ignored (same instruction still presented); -> IDLE.
- stall_req (combinational) = (state∈{MUL,DIV}) | (state==IDLE & op_valid & op∈{0..3} & !flush).
- Total stall for an accepted op: MULT 1+MUL_CYCLES cycles, DIV 1+32 cycles; the instruction advances at the end of the DONE cycle.
- Divide by zero: no trap. Result is the natural restoring outcome on magnitudes (q=0xFFFFFFFF, r=|a|), then sign fixups apply. Example: DIVU 7/0 gives lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Flush:
  - In MUL/DIV/DONE: next state IDLE; no hi/lo write. A flush on the final MUL/DIV edge also suppresses the write.
  - Asserted alongside MTHI/MTLO in IDLE: write suppressed.
  - Flush has priority over everything except reset.
- hi/lo change only at the final MUL/DIV edge or an MTHI/MTLO edge; otherwise held.

Optional Feature:
- Macro: HILO_DIV_EARLY_EN.
- Defined: in IDLE, a DIV/DIVU with |b| > |a| and b≠0 skips DIV. Result is written at the accept edge (lo=0, hi=a) and the unit goes straight to DONE, giving a total stall of 1 cycle.
- Undefined: every divide takes the full 32 iterations regardless of operands.

Test Plan:
- Reset while DIV is mid-iteration (cnt=15) -> same cycle: stall_req=0, hi=lo=0, state IDLE; subsequent MTLO 0x1234 gives lo=0x1234.
- MULT src_a=0xFFFFFFFE (-2), src_b=3, MUL_CYCLES=3 -> stall_req high 4 cycles, done pulse next cycle, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with same operands -> hi=0x2, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> after 33 stall cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- Flush asserted on 20th DIV cycle, hi=0xAAAA0000 beforehand -> next cycle IDLE, stall_req=0, no done, hi still 0xAAAA0000.
- MTHI 0xDEADBEEF with flush=1 -> hi unchanged; MTHI without flush -> hi=0xDEADBEEF next cycle, stall_req never high.
- With HILO_DIV_EARLY_EN: DIVU 3/10 -> stall 1 cycle, lo=0, hi=3; without macro -> 33-cycle stall, same result.
